// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR MAC stage and its rounding helper.
package fir_pkg;

    localparam int FIR_DW    = 16;
    localparam int FIR_TAPS  = 8;
    localparam int FIR_ACC_W = 2 * FIR_DW + $clog2(FIR_TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam logic [FIR_DW-1:0] SAT_MAX   = 16'h7FFF;
    localparam logic [FIR_DW-1:0] SAT_MIN   = 16'h8000;
    localparam logic [FIR_DW-1:0] COEF0_RST = 16'h7FFF;

    // Width-generic saturation limits (valid for dw <= 31).
    function automatic int sat_hi(input int dw);
        return (1 <<< (dw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int dw);
        return -(1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Q-format reduction: round-half-up by 2^(DW-2), shift right DW-1, saturate to DW bits.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int ACC_W = FIR_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [DW-1:0]    res,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] HI       = (ACC_W + 1)'(sat_hi(DW));
    localparam logic signed [ACC_W:0] LO       = (ACC_W + 1)'(sat_lo(DW));
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (DW - 2);

    logic signed [ACC_W:0] rnd_sum;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        // One guard bit so the rounding add can never wrap.
        rnd_sum = $signed({acc[ACC_W-1], acc}) + RND_HALF;
        shifted = rnd_sum >>> (DW - 1);
        res     = shifted[DW-1:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            res = HI[DW-1:0];
            sat = 1'b1;
        end else if (shifted < LO) begin
            res = LO[DW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac.sv
// Time-multiplexed FIR: one shared multiplier walks the taps, one result pulse per sample.
module fir_mac
    import fir_pkg::*;
#(
    parameter int TAPS = FIR_TAPS,
    parameter int DW   = FIR_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fir_en,
    input  logic                     sample_req,
    input  logic [DW-1:0]            sample_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DW-1:0]            coef_wdata,
    input  logic                     clr_flags,
    output logic [DW-1:0]            fir_write_data,
    output logic                     fir_write_req,
    output logic                     busy,
    output logic                     drop_flag,
    output logic                     sat_flag
);

    localparam int KW    = $clog2(TAPS);
    localparam int ACC_W = 2 * DW + KW;
    localparam logic signed [DW-1:0] C0_RST = DW'(sat_hi(DW));

    fir_state_t state, state_nxt;

    logic signed [DW-1:0]    x_q [TAPS];
    logic signed [DW-1:0]    c_q [TAPS];
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q, acc_nxt;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW-1:0]    rs_res;
    logic                    rs_sat;
    logic                    accept, coef_ok, last, drop_set, sat_set;

    assign accept   = (state == IDLE) && sample_req && fir_en;
    assign coef_ok  = (state == IDLE) && coef_we;
    assign last     = (state == MAC) && (k_q == KW'(TAPS - 1));
    assign drop_set = (state != IDLE) && ((sample_req && fir_en) || coef_we);
    assign sat_set  = last && rs_sat;

    assign prod    = x_q[k_q] * c_q[k_q];
    assign acc_nxt = acc_q + ACC_W'(prod);

    // Rounded from acc_nxt so the result register loads on the last MAC edge.
    fir_round_sat #(.DW(DW), .ACC_W(ACC_W)) u_round_sat (
        .acc (acc_nxt),
        .res (rs_res),
        .sat (rs_sat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last)   state_nxt = OUT;
            OUT:                 state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            k_q            <= '0;
            acc_q          <= '0;
            fir_write_data <= '0;
            fir_write_req  <= 1'b0;
            drop_flag      <= 1'b0;
            sat_flag       <= 1'b0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != IDLE);
            fir_write_req <= last;
            if (accept) begin
                acc_q <= '0;
                k_q   <= '0;
            end else if (state == MAC) begin
                acc_q <= acc_nxt;
                k_q   <= k_q + 1'b1;
            end
            if (last) fir_write_data <= rs_res;
            if (drop_set)       drop_flag <= 1'b1;
            else if (clr_flags) drop_flag <= 1'b0;
            if (sat_set)        sat_flag  <= 1'b1;
            else if (clr_flags) sat_flag  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
        end else if (accept) begin
            x_q[0] <= sample_data;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) c_q[i] <= '0;
            c_q[0] <= C0_RST;
        end else if (coef_ok) begin
            c_q[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac: expected results queued at issue, checked by a result monitor.
module tb_fir_mac;

    localparam int TAPS = 8;
    localparam int DW   = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            fir_en;
    logic            sample_req;
    logic [DW-1:0]   sample_data;
    logic            coef_we;
    logic [2:0]      coef_addr;
    logic [DW-1:0]   coef_wdata;
    logic            clr_flags;
    logic [DW-1:0]   fir_write_data;
    logic            fir_write_req;
    logic            busy;
    logic            drop_flag;
    logic            sat_flag;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q [$];

    fir_mac #(.TAPS(TAPS), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fir_en         (fir_en),
        .sample_req     (sample_req),
        .sample_data    (sample_data),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_wdata     (coef_wdata),
        .clr_flags      (clr_flags),
        .fir_write_data (fir_write_data),
        .fir_write_req  (fir_write_req),
        .busy           (busy),
        .drop_flag      (drop_flag),
        .sat_flag       (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && fir_write_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got pulse with %h expected no pulse", fir_write_data);
            end else begin
                check("result", {16'h0, fir_write_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input logic [2:0] a, input logic [DW-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        tick();
        coef_we = 1'b0;
    endtask

    // Issues a sample; afterwards we sit in cycle 1 of the frame.
    task automatic send(input logic [DW-1:0] d);
        sample_req = 1'b1; sample_data = d;
        tick();
        sample_req = 1'b0;
    endtask

    task automatic send_wait(input logic [DW-1:0] exp, input logic [DW-1:0] d);
        exp_q.push_back(exp);
        send(d);
        repeat (TAPS + 1) tick();
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    logic [DW-1:0] neg_exp [8] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFC,
                                   16'h8000, 16'h8000, 16'h8000, 16'h8000};

    initial begin
        int cyc;
        reset = 1'b0; fir_en = 1'b1; sample_req = 1'b0; sample_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; clr_flags = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {11'h0, fir_write_data, fir_write_req, busy, drop_flag, sat_flag}, 32'h0);
        reset = 1'b1;
        tick();

        // Default coefficients (c0=0x7FFF): latency and busy window.
        exp_q.push_back(16'h4000);
        send(16'h4000);
        cyc = 1;
        check("busy_cycle1", {31'h0, busy}, 32'h1);
        while (!fir_write_req && cyc < 20) begin
            tick();
            cyc++;
        end
        check("req_cycle", cyc, TAPS + 1);
        tick();
        check("busy_after", {31'h0, busy}, 32'h0);
        check("flags_default", {30'h0, drop_flag, sat_flag}, 32'h0);

        // All taps 0x1000; delay line fills with 0x4000 one sample at a time.
        for (int i = 0; i < TAPS; i++) wcoef(3'(i), 16'h1000);
        for (int i = 1; i <= 8; i++) send_wait(16'(((i + 1 > 8) ? 8 : i + 1) * 16'h0800), 16'h4000);
        check("sat_after_unity", {31'h0, sat_flag}, 32'h0);

        // Full-scale positive then negative.
        for (int i = 0; i < TAPS; i++) wcoef(3'(i), 16'h7FFF);
        for (int i = 0; i < 8; i++) send_wait(16'h7FFF, 16'h7FFF);
        check("sat_pos", {31'h0, sat_flag}, 32'h1);
        for (int i = 0; i < 8; i++) send_wait(neg_exp[i], 16'h8000);
        pulse_clr();
        check("clr_all", {30'h0, drop_flag, sat_flag}, 32'h0);

        // Sample arriving 3 cycles into a frame is dropped.
        wcoef(3'd0, 16'h7FFF);
        for (int i = 1; i < TAPS; i++) wcoef(3'(i), 16'h0000);
        exp_q.push_back(16'h1234);
        send(16'h1234);
        repeat (2) tick();
        send(16'h5555);
        repeat (TAPS + 2 - 4) tick();
        check("drop_set", {31'h0, drop_flag}, 32'h1);
        pulse_clr();
        check("drop_clr", {31'h0, drop_flag}, 32'h0);
        // Tap 1 alone exposes x[1]: the dropped sample never entered the line.
        wcoef(3'd0, 16'h0000);
        wcoef(3'd1, 16'h7FFF);
        send_wait(16'h1234, 16'h0777);

        // Coefficient write during MAC is refused.
        exp_q.push_back(16'h0777);
        send(16'h0100);
        repeat (2) tick();
        wcoef(3'd1, 16'h0000);
        repeat (TAPS + 2 - 4) tick();
        check("coef_busy_drop", {31'h0, drop_flag}, 32'h1);
        pulse_clr();
        send_wait(16'h0100, 16'h0200);

        // Coefficient write and sample in the same idle cycle: new coefficient used.
        exp_q.push_back(16'h0500);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h7FFF;
        sample_req = 1'b1; sample_data = 16'h0300;
        tick();
        coef_we = 1'b0; sample_req = 1'b0;
        repeat (TAPS + 1) tick();
        check("same_cycle_noflag", {31'h0, drop_flag}, 32'h0);

        // Disabled stage ignores samples silently.
        fir_en = 1'b0;
        send(16'h7000);
        repeat (12) tick();
        check("disabled_idle", {29'h0, busy, drop_flag, sat_flag}, 32'h0);
        check("data_held", {16'h0, fir_write_data}, 32'h0500);
        fir_en = 1'b1;

        // Reset mid-MAC: outputs clear at once, no late result.
        send(16'h2222);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("async_reset", {11'h0, fir_write_data, fir_write_req, busy, drop_flag, sat_flag}, 32'h0);
        tick();
        reset = 1'b1;
        repeat (15) tick();
        check("post_reset_idle", {30'h0, busy, fir_write_req}, 32'h0);
        check("pending_results", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_mac.md
# fir_mac

- Time-multiplexed FIR filter stage: accepts 16-bit signed samples, runs one multiply-accumulate per clock over a programmable coefficient set, emits a rounded and saturated 16-bit result.
- Sits directly upstream of the range-check/LED monitor stage.
- Its `fir_write_data` / `fir_write_req` outputs drive that stage's FIR result inputs.
- One result pulse per accepted sample.

## Interface
Parameters:
- `TAPS`, 8: number of filter taps, power of two, 2..32.
- `DW`, 16: sample, coefficient and result width (Q1.15 signed).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `fir_en`, in, 1: stage enable; when low, new samples are ignored.
- `sample_req`, in, 1: one-cycle strobe, `sample_data` valid.
- `sample_data`, in, DW: signed input sample.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, log2(TAPS): coefficient index; 0 multiplies the newest sample.
- `coef_wdata`, in, DW: signed coefficient.
- `clr_flags`, in, 1: clears the sticky flags.
- `fir_write_data`, out, DW: filter result, held until the next result.
- `fir_write_req`, out, 1: one-cycle result-valid pulse.
- `busy`, out, 1: high whenever the state is not IDLE.
- `drop_flag`, out, 1: sticky; a sample was lost.
- `sat_flag`, out, 1: sticky; a result was saturated.

## Operation
State machine: IDLE -> MAC -> OUT -> IDLE.
- **IDLE**
  - If `sample_req` is high and `fir_en` is high: shift the delay line (`x[0]` <= `sample_data`, `x[i]` <= `x[i-1]`), clear the accumulator, clear the tap counter, go to MAC.
  - If `fir_en` is low: `sample_req` is ignored and no flag is set.
- **MAC**
  - Each cycle: acc += `x[k]` * `c[k]`, k++.
  - After k = TAPS-1 is accumulated, go to OUT.
- **OUT**
  - `fir_write_data` <= sat16((acc + 2^14) >>> 15).
  - Pulse `fir_write_req` for one cycle.
  - Go to IDLE.

Arithmetic:
- Products are 2·DW bits, signed.
- Accumulator is 2·DW + log2(TAPS) bits and never wraps.
- Saturation limits are 0x7FFF and 0x8000. Each saturation event sets `sat_flag`.

Flags and side inputs:
- `sample_req` while `busy`: sample discarded, delay line untouched, `drop_flag` set.
- `coef_we` is honoured only in IDLE. While busy it is ignored and `drop_flag` is set.
- `coef_we` and an accepted `sample_req` in the same IDLE cycle: both take effect. The MAC uses the new coefficient.
- `clr_flags` clears both flags. If it coincides with a new set event, the set wins.
- `fir_en` falling during MAC/OUT: the current result still completes.

Reset (asserted asynchronously, including mid-MAC):
- State IDLE, delay line 0, accumulator 0.
- Coefficients: `c[0]`=0x7FFF, all others 0.
- `fir_write_data`=0, `fir_write_req`=0, `busy`=0, both flags 0.
- No partial result is emitted after release.

## Timing
- `sample_req` sampled high in IDLE at cycle 0 -> `busy` high in cycles 1..TAPS+1.
- `fir_write_req` high in cycle TAPS+1 only; `fir_write_data` valid from that cycle on.
- Next sample accepted in cycle TAPS+2, where `busy` is 0.
- Maximum rate: one sample per TAPS+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- A coefficient write at cycle n is visible to a sample accepted at cycle n or later.

## Structure
- Package `fir_pkg`:
  - DW and TAPS defaults.
  - ACC_W = 2·DW + log2(TAPS).
  - State encoding IDLE/MAC/OUT.
  - Reset coefficient constant (0x7FFF at tap 0).
  - Saturation limits.
- Sub-module `fir_round_sat`: combinational, ACC_W in -> DW out plus a saturated bit. Reusable by the wavelet stage.
- Delay line and coefficients are register arrays in the top module; a single multiplier is shared through the tap mux.

## Test plan
- Reset defaults, TAPS=8: sample 0x4000 -> `fir_write_req` in cycle 9, data 0x4000 (approximately, per the c0=0x7FFF rounding); flags 0.
- Load all eight coefficients to 0x1000, then feed eight samples of 0x4000 spaced 10 cycles apart -> last result 0x4000, `sat_flag` 0.
- Load all coefficients to 0x7FFF, feed eight samples of 0x7FFF -> result 0x7FFF, `sat_flag`=1. Repeat with samples 0x8000 -> 0x8000.
- Second `sample_req` 3 cycles after the first -> discarded, `drop_flag`=1, only one `fir_write_req`. Then `clr_flags` -> flag 0.
- `coef_we` during MAC -> coefficient unchanged, `drop_flag`=1.
- `fir_en`=0 with `sample_req` -> no pulse, no flag. Reset asserted mid-MAC -> outputs 0 immediately, no `fir_write_req` after release.
